fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register.
- Feeds the 32-bit instruction word consumed by the decode stage's control unit.
- Holds the PC, drives the instruction-memory address, and accepts redirects from branch/jump resolution.
- Applies stall and flush, presents a valid-tagged instruction with its PC+4 to decode, and keeps fetch/flush event counters.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 36 +++
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants for the fetch stage: instruction width,
// FSM state encodings, the bubble instruction and a word-alignment helper.
package fetch_stage_pkg;

    localparam int INSTR_W = 32;

    // Fetch FSM encodings (kept as plain constants for legacy compatibility)
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // sll $0,$0,0 : harmless when it reaches decode
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of instruction-memory, control and IF/ID signals of the fetch stage.
// The master modport is the fetch stage; the slave modport is its environment
// (instruction memory, hazard unit, branch resolution and decode).
//
// There is no valid/ready handshake here: instruction memory answers
// combinationally in the same cycle, Stall is the only backpressure, and
// IF_ID_Valid qualifies the registered instruction every cycle.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [31:0]        InstrAddr;
    logic [INSTR_W-1:0] InstrData;
    logic               Stall;
    logic               Redirect;
    logic [31:0]        RedirectPC;
    logic               Halt;
    logic [INSTR_W-1:0] IF_ID_Instruction;
    logic [31:0]        IF_ID_PCPlus4;
    logic               IF_ID_Valid;
    logic [31:0]        FetchCount;
    logic [31:0]        FlushCount;
    logic [1:0]         FetchState;   // debug view of the fetch FSM

    modport master (
        output InstrAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
               FetchCount, FlushCount, FetchState,
        input  InstrData, Stall, Redirect, RedirectPC, Halt
    );

    modport slave (
        input  InstrAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
               FetchCount, FlushCount, FetchState,
        output InstrData, Stall, Redirect, RedirectPC, Halt
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush loads a bubble and wins over load;
// with neither asserted the register holds (stall).
module fetch_stage_if_id_reg #(
    parameter logic [31:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pcplus4_in,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    // Capture a fetched instruction, insert a bubble, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= NOP_WORD;
            pcplus4 <= 32'd0;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= NOP_WORD;
            pcplus4 <= 32'd0;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= instr_in;
            pcplus4 <= pcplus4_in;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (WAIT/RUN/HALT),
// redirect/stall/halt handling, fetch and flush event counters, and the
// IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
    input  logic           Clk,
    input  logic           Reset,
    fetch_stage_if.master  fif
);
    import fetch_stage_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        ifid_load;
    logic        ifid_flush;
    logic        fetch_inc;
    logic        flush_inc;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    assign pc_plus4       = pc + 32'd4;   // wraps modulo 2^32
    assign fif.InstrAddr  = pc;
    assign fif.FetchState = state;
    assign fif.FetchCount = fetch_count;
    assign fif.FlushCount = flush_count;

    // Next-state, next-PC and IF/ID control; Redirect beats Stall in RUN
    always_comb begin
        pc_next    = pc;
        state_next = state;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        fetch_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state)
            ST_WAIT: begin
                ifid_flush = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (fif.Redirect) begin
                    pc_next    = align_word(fif.RedirectPC);
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (!fif.Stall) begin
                    pc_next    = pc_plus4;
                    ifid_load  = 1'b1;
                    fetch_inc  = 1'b1;
                end
                if (fif.Halt) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                // Unused encoding: emit a bubble and restart cleanly
                ifid_flush = 1'b1;
                state_next = ST_WAIT;
            end
        endcase
    end

    // PC and FSM state registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc    <= align_word(RESET_PC);
            state <= ST_WAIT;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    // Event counters, both wrapping modulo 2^32
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetch_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (fetch_inc) fetch_count <= fetch_count + 32'd1;
            if (flush_inc) flush_count <= flush_count + 32'd1;
        end
    end

    fetch_stage_if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk        (Clk),
        .rst_n      (Reset),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .instr_in   (fif.InstrData),
        .pcplus4_in (pc_plus4),
        .instr      (fif.IF_ID_Instruction),
        .pcplus4    (fif.IF_ID_PCPlus4),
        .valid      (fif.IF_ID_Valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory is modelled as
// InstrData = InstrAddr ^ 32'hA5A5_0000, so each expected IF/ID word below
// is hand-derived from the PC it was fetched from.
module tb_fetch_stage;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .fif   (fif)
    );

    // Combinational instruction memory
    assign fif.InstrData = fif.InstrAddr ^ 32'hA5A5_0000;

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr, input logic vld,
                           input logic [31:0] instr, input logic [31:0] p4,
                           input logic [31:0] fc, input logic [31:0] flc,
                           input logic [1:0] st);
        chk({tag, ".addr"},  fif.InstrAddr, addr);
        chk({tag, ".valid"}, {31'd0, fif.IF_ID_Valid}, {31'd0, vld});
        chk({tag, ".instr"}, fif.IF_ID_Instruction, instr);
        chk({tag, ".pc4"},   fif.IF_ID_PCPlus4, p4);
        chk({tag, ".fetch"}, fif.FetchCount, fc);
        chk({tag, ".flush"}, fif.FlushCount, flc);
        chk({tag, ".state"}, {30'd0, fif.FetchState}, {30'd0, st});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        Reset          = 1'b0;
        fif.Stall      = 1'b0;
        fif.Redirect   = 1'b0;
        fif.RedirectPC = 32'h0;
        fif.Halt       = 1'b0;

        // Reset state, then release between edges
        #22;
        chk_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 2'd0);
        Reset = 1'b1;
        #1;
        chk_all("released", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 2'd0);

        // Free running: WAIT cycle, then sequential fetch
        tick(); chk_all("wait", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 2'd1);
        tick(); chk_all("run1", 32'h4, 1'b1, 32'hA5A5_0000, 32'h4, 32'd1, 32'd0, 2'd1);
        tick(); chk_all("run2", 32'h8, 1'b1, 32'hA5A5_0004, 32'h8, 32'd2, 32'd0, 2'd1);
        tick(); chk_all("run3", 32'hC, 1'b1, 32'hA5A5_0008, 32'hC, 32'd3, 32'd0, 2'd1);
        tick(); chk_all("run4", 32'h10, 1'b1, 32'hA5A5_000C, 32'h10, 32'd4, 32'd0, 2'd1);

        // Stall three cycles at PC=0x10
        fif.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", 32'h10, 1'b1, 32'hA5A5_000C, 32'h10, 32'd4, 32'd0, 2'd1);
        end
        fif.Stall = 1'b0;
        tick(); chk_all("unstall", 32'h14, 1'b1, 32'hA5A5_0010, 32'h14, 32'd5, 32'd0, 2'd1);

        // Redirect wins over Stall; target is aligned
        fif.Stall      = 1'b1;
        fif.Redirect   = 1'b1;
        fif.RedirectPC = 32'h0000_0103;
        tick(); chk_all("redir_bubble", 32'h100, 1'b0, 32'h0, 32'h0, 32'd5, 32'd1, 2'd1);
        fif.Stall    = 1'b0;
        fif.Redirect = 1'b0;
        tick(); chk_all("redir_target", 32'h104, 1'b1, 32'hA5A5_0100, 32'h104, 32'd6, 32'd1, 2'd1);

        // PC wrap at the top of the address space
        fif.Redirect   = 1'b1;
        fif.RedirectPC = 32'hFFFF_FFFC;
        tick(); chk_all("wrap_redir", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'd6, 32'd2, 2'd1);
        fif.Redirect = 1'b0;
        tick(); chk_all("wrap_fetch", 32'h0, 1'b1, 32'h5A5A_FFFC, 32'h0, 32'd7, 32'd2, 2'd1);
        tick(); chk_all("wrap_next", 32'h4, 1'b1, 32'hA5A5_0000, 32'h4, 32'd8, 32'd2, 2'd1);

        // Halt together with Redirect: redirect taken, then HALT
        fif.Halt       = 1'b1;
        fif.Redirect   = 1'b1;
        fif.RedirectPC = 32'h0000_0040;
        tick(); chk_all("halt_redir", 32'h40, 1'b0, 32'h0, 32'h0, 32'd8, 32'd3, 2'd2);
        fif.Halt       = 1'b0;
        fif.RedirectPC = 32'h0000_0080;
        for (int i = 0; i < 10; i++) begin
            fif.Redirect = i[0];
            fif.Stall    = i[1];
            tick(); chk_all("halted", 32'h40, 1'b0, 32'h0, 32'h0, 32'd8, 32'd3, 2'd2);
        end
        fif.Redirect = 1'b0;
        fif.Stall    = 1'b0;

        // Asynchronous reset out of HALT
        #3;
        Reset = 1'b0;
        #1;
        chk_all("areset_halt", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 2'd0);
        Reset = 1'b1;
        tick(); chk_all("re_wait", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 2'd1);
        tick(); chk_all("re_run1", 32'h4, 1'b1, 32'hA5A5_0000, 32'h4, 32'd1, 32'd0, 2'd1);
        tick();
        tick(); chk_all("re_run3", 32'hC, 1'b1, 32'hA5A5_0008, 32'hC, 32'd3, 32'd0, 2'd1);

        // Asynchronous reset in the middle of running
        #3;
        Reset = 1'b0;
        #1;
        chk_all("areset_run", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 2'd0);
        Reset = 1'b1;
        tick(); chk_all("post_wait", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 2'd1);
        tick(); chk_all("post_run1", 32'h4, 1'b1, 32'hA5A5_0000, 32'h4, 32'd1, 32'd0, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
